// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/half/word transfers with byte-lane enables, programmable
// wait states, two-cycle ERROR response, and a post-reset clear engine zeroing the array.
module ahb_sram_slave #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned MemWords = MEM_BYTES / 4;
  localparam int unsigned WordAw   = $clog2(MemWords);
  localparam int unsigned ByteAw   = WordAw + 2;
  localparam logic [WordAw-1:0] LastWord = WordAw'(MemWords - 1);
  localparam logic [3:0]        WaitMax  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StInit, StIdle, StData, StErr1, StErr2} state_e;

  logic [31:0]       r_mem [MemWords];
  state_e            r_state, w_state_d;
  logic [WordAw-1:0] r_clear_ptr, w_clear_ptr_d;
  logic [3:0]        r_wait_cnt, w_wait_cnt_d;
  logic              r_pending, w_pending_d;
  logic [ByteAw-1:0] r_off, w_off_d;
  logic [1:0]        r_size, w_size_d;
  logic              r_write, w_write_d;
  logic              r_err, w_err_d;

  logic              w_accept;
  logic              w_can_accept;
  logic              w_illegal;
  logic [31:0]       w_off_full;
  logic [3:0]        w_lane_be;
  logic              w_mem_we;
  logic [WordAw-1:0] w_mem_idx;
  logic [31:0]       w_mem_wdata;
  logic [3:0]        w_mem_be;
  logic              w_unused;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats identically.
  assign w_unused   = HTRANS[0];
  assign w_accept   = HSEL & HREADY & HTRANS[1];
  assign w_off_full = HADDR - BASE_ADDR;

  // Legality of the address phase currently on the bus.
  always_comb begin
    w_illegal = 1'b0;
    if (HSIZE > 3'd2) w_illegal = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0]) w_illegal = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) w_illegal = 1'b1;
    if (HADDR < BASE_ADDR) w_illegal = 1'b1;
    if (w_off_full >= 32'(MEM_BYTES)) w_illegal = 1'b1;
  end

  // Byte-lane enables of the latched transfer (little-endian lanes).
  always_comb begin
    w_lane_be = 4'b0000;
    case (r_size)
      2'd0:    w_lane_be = 4'b0001 << r_off[1:0];
      2'd1:    w_lane_be = r_off[1] ? 4'b1100 : 4'b0011;
      default: w_lane_be = 4'b1111;
    endcase
  end

  // Next-state, bus responses and array write port.
  always_comb begin
    w_state_d     = r_state;
    w_clear_ptr_d = r_clear_ptr;
    w_wait_cnt_d  = 4'd0;
    w_pending_d   = r_pending;
    w_off_d       = r_off;
    w_size_d      = r_size;
    w_write_d     = r_write;
    w_err_d       = r_err;
    w_can_accept  = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_idx     = r_off[ByteAw-1:2];
    w_mem_wdata   = HWDATA;
    w_mem_be      = w_lane_be;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    HRDATA        = 32'h0;

    unique case (r_state)
      StInit: begin
        // A transfer caught during the clear stalls until the last word is zeroed.
        HREADYOUT     = ~r_pending;
        w_can_accept  = ~r_pending;
        w_mem_we      = 1'b1;
        w_mem_idx     = r_clear_ptr;
        w_mem_wdata   = 32'h0;
        w_mem_be      = 4'b1111;
        w_clear_ptr_d = r_clear_ptr + WordAw'(1);
        if (r_clear_ptr == LastWord) begin
          if (r_pending) w_state_d = r_err ? StErr1 : StData;
          else           w_state_d = StIdle;
        end
      end
      StIdle: begin
        w_can_accept = 1'b1;
      end
      StData: begin
        if (r_wait_cnt == WaitMax) begin
          if (r_write) w_mem_we = 1'b1;
          else         HRDATA = r_mem[r_off[ByteAw-1:2]];
          w_state_d    = StIdle;
          w_pending_d  = 1'b0;
          w_can_accept = 1'b1;
        end else begin
          HREADYOUT    = 1'b0;
          w_wait_cnt_d = r_wait_cnt + 4'd1;
        end
      end
      StErr1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        w_state_d = StErr2;
      end
      StErr2: begin
        HRESP        = 1'b1;
        w_state_d    = StIdle;
        w_pending_d  = 1'b0;
        w_can_accept = 1'b1;
      end
    endcase

    if (w_can_accept && w_accept) begin
      w_pending_d = 1'b1;
      w_off_d     = w_off_full[ByteAw-1:0];
      w_size_d    = HSIZE[1:0];
      w_write_d   = HWRITE;
      w_err_d     = w_illegal;
      if (r_state != StInit || r_clear_ptr == LastWord) begin
        w_state_d = w_illegal ? StErr1 : StData;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StInit;
      r_clear_ptr <= '0;
      r_wait_cnt  <= 4'd0;
      r_pending   <= 1'b0;
      r_off       <= '0;
      r_size      <= 2'd0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_clear_ptr <= w_clear_ptr_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_pending   <= w_pending_d;
      r_off       <= w_off_d;
      r_size      <= w_size_d;
      r_write     <= w_write_d;
      r_err       <= w_err_d;
    end
  end

  // Array write port; reset suppresses any in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_mem_be[k]) r_mem[w_mem_idx][8*k +: 8] <= w_mem_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 KB/base 0/no waits and 256 B/high base/3 waits)
// driven with directed and random pipelined AHB traffic, checked against a byte-array model.
module tb_ahb_sram_slave;

  localparam int unsigned MemB0 = 1024;
  localparam logic [31:0] Base0 = 32'h0000_0000;
  localparam int unsigned Ws0   = 0;
  localparam int unsigned MemB1 = 256;
  localparam logic [31:0] Base1 = 32'h2000_0000;
  localparam int unsigned Ws1   = 3;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2] = '{1'b1, 1'b1};
  logic        hsel [2];
  logic [31:0] haddr [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata0, hrdata1;
  logic        hro0, hro1, hresp0, hresp1;

  int          cnt [2];
  logic [7:0]  mdl [2][1024];
  tx_t         q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  ahb_sram_slave #(.MEM_BYTES(MemB0), .BASE_ADDR(Base0), .WAIT_STATES(Ws0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hro0),
    .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
  );

  ahb_sram_slave #(.MEM_BYTES(MemB1), .BASE_ADDR(Base1), .WAIT_STATES(Ws1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hro1),
    .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1)
  );

  // Cycles since the last reset edge; cycle 0 is the first cycle after reset.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) cnt[d] <= reset[d] ? 0 : cnt[d] + 1;
  end

  function automatic int unsigned memb_of(input int d);
    return (d == 0) ? MemB0 : MemB1;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? Base0 : Base1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? int'(Ws0) : int'(Ws1);
  endfunction

  function automatic bit is_err(input int d, input logic [2:0] size, input logic [31:0] addr);
    longint a;
    longint b;
    a = longint'(addr);
    b = longint'(base_of(d));
    if (size > 3'd2) return 1'b1;
    if (a % (longint'(1) << size) != 0) return 1'b1;
    if (a < b) return 1'b1;
    if (a - b >= longint'(memb_of(d))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input logic [31:0] addr);
    int off;
    logic [31:0] w;
    off = int'(addr - base_of(d)) & ~3;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[d][off + i];
    return w;
  endfunction

  task automatic mdl_write(input int d, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int off;
    int b;
    off = int'(addr - base_of(d));
    for (int i = 0; i < (1 << size); i++) begin
      b = off + i;
      mdl[d][b] = wdata[8*(b % 4) +: 8];
    end
  endtask

  task automatic mdl_clear(input int d);
    for (int b = 0; b < 1024; b++) mdl[d][b] = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic sample(input int d, output logic rdy, output logic rsp, output logic [31:0] rd);
    if (d == 0) begin
      rdy = hro0; rsp = hresp0; rd = hrdata0;
    end else begin
      rdy = hro1; rsp = hresp1; rd = hrdata1;
    end
  endtask

  task automatic drive(input int d, input tx_t t);
    hsel[d] = t.hsel; htrans[d] = t.htrans; hwrite[d] = t.wr;
    hsize[d] = t.size; haddr[d] = t.addr;
  endtask

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hsize[d] = 3'd0; haddr[d] = 32'h0;
  endtask

  task automatic push_tx(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    tx_t t;
    t.hsel = 1'b1; t.htrans = 2'b10; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    q.push_back(t);
  endtask

  // Unselected cycles still carry a NONSEQ-looking write so HSEL gating matters.
  task automatic push_idle(input int n);
    tx_t t;
    for (int i = 0; i < n; i++) begin
      t.hsel = 1'b0; t.htrans = 2'b10; t.wr = 1'b1; t.size = 3'd2;
      t.addr = $urandom() & 32'h0000_00FC; t.wdata = $urandom();
      q.push_back(t);
    end
  endtask

  // Selected but HTRANS is IDLE or BUSY: no transfer.
  task automatic push_noxfer(input logic [1:0] tr, input logic [31:0] addr);
    tx_t t;
    t.hsel = 1'b1; t.htrans = tr; t.wr = 1'b1; t.size = 3'd2; t.addr = addr; t.wdata = 32'h0;
    q.push_back(t);
  endtask

  task automatic push_random(input int d, input int n);
    int unsigned r;
    int unsigned off;
    int unsigned mask;
    logic [2:0] sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        push_idle(1);
      end else if (r == 1) begin
        push_noxfer(2'($urandom_range(0, 1)), base_of(d) + ($urandom_range(0, 15) * 4));
      end else begin
        sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, memb_of(d) - 1)
                                          : $urandom_range(0, 31);
        if (sz <= 3'd2 && $urandom_range(0, 9) != 0) begin
          mask = (32'd1 << sz) - 32'd1;
          off = off & ~mask;
        end
        a = base_of(d) + off;
        r = $urandom_range(0, 39);
        if (r == 0) a = base_of(d) + memb_of(d) + ($urandom_range(0, 7) * 4);
        if (r == 1) a = base_of(d) - ($urandom_range(1, 4) * 4);
        push_tx(1'($urandom_range(0, 1)), sz, a, $urandom());
      end
    end
  endtask

  // Plays the queue as a pipelined AHB master (HREADY = HREADYOUT) and checks every cycle.
  task automatic run_q(input int d);
    int   idx = 0;
    int   guard = 0;
    bit   dp_v = 1'b0;
    tx_t  dp;
    bit   dp_err = 1'b0;
    int   dp_w = 0;
    int   dp_exp_w = 0;
    int   c_addr = 0;
    int   mw;
    logic rdy, rsp;
    logic [31:0] rd;
    mw = int'(memb_of(d) / 4);
    while ((idx < q.size() || dp_v) && guard < 4000) begin
      guard++;
      if (idx < q.size()) drive(d, q[idx]);
      else drive_idle(d);
      hwdata[d] = (dp_v && dp.wr) ? dp.wdata : $urandom();
      @(negedge clk);
      sample(d, rdy, rsp, rd);
      c_addr = cnt[d];
      if (dp_v) begin
        if (rdy !== 1'b1) dp_w++;
        check("hresp", 32'(rsp), 32'(dp_err));
        check("hrdata", rd, (rdy === 1'b1 && !dp_err && !dp.wr) ? mdl_read(d, dp.addr) : 32'h0);
        if (rdy === 1'b1) begin
          check("wait_cycles", 32'(dp_w), 32'(dp_exp_w));
          if (!dp_err && dp.wr) mdl_write(d, dp.size, dp.addr, dp.wdata);
        end
      end else begin
        check("idle_hreadyout", 32'(rdy), 32'd1);
        check("idle_hresp", 32'(rsp), 32'd0);
        check("idle_hrdata", rd, 32'h0);
      end
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        dp_v = 1'b0;
        if (idx < q.size()) begin
          if (q[idx].hsel && q[idx].htrans[1]) begin
            dp_v = 1'b1;
            dp = q[idx];
            dp_err = is_err(d, dp.size, dp.addr);
            dp_w = 0;
            // Stall for the rest of the clear (if any), then the response's own low cycles.
            dp_exp_w = ((c_addr < mw - 1) ? (mw - 1 - c_addr) : 0) + (dp_err ? 1 : ws_of(d));
          end
          idx++;
        end
      end
    end
    check("seq_done", 32'(q.size() - idx + int'(dp_v)), 32'd0);
    drive_idle(d);
    q.delete();
  endtask

  // Reset lands in the second wait cycle of a word write; the write must not survive.
  task automatic reset_mid_write(input int d, input logic [31:0] addr);
    logic rdy, rsp;
    logic [31:0] rd;
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = 1'b1; hsize[d] = 3'd2; haddr[d] = addr;
    @(posedge clk);
    #1;
    drive_idle(d);
    hwdata[d] = 32'hCAFE_F00D;
    @(negedge clk);
    sample(d, rdy, rsp, rd);
    check("rst_wait0_hreadyout", 32'(rdy), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    sample(d, rdy, rsp, rd);
    check("rst_wait1_hreadyout", 32'(rdy), 32'd0);
    reset[d] = 1'b1;
    @(posedge clk);
    #1;
    reset[d] = 1'b0;
    mdl_clear(d);
    @(negedge clk);
    sample(d, rdy, rsp, rd);
    check("rst_hreadyout", 32'(rdy), 32'd1);
    check("rst_hresp", 32'(rsp), 32'd0);
    check("rst_hrdata", rd, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      hwdata[d] = 32'h0;
      mdl_clear(d);
    end
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // 1 KB, base 0, zero waits: read issued at cycle 5 of the clear, then directed traffic.
    push_idle(5);
    push_tx(1'b0, 3'd2, 32'h0000_03FC, 32'h0);
    push_tx(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    push_tx(1'b1, 3'd0, 32'h0000_0011, 32'hAAAA_AAAA);
    push_tx(1'b1, 3'd1, 32'h0000_0012, 32'h1234_1234);
    push_tx(1'b0, 3'd2, 32'h0000_0010, 32'h0);
    push_tx(1'b0, 3'd2, 32'h0000_0002, 32'h0);
    push_tx(1'b1, 3'd2, 32'h0000_0400, 32'h5555_5555);
    push_tx(1'b0, 3'd2, 32'h0000_0000, 32'h0);
    push_tx(1'b0, 3'd3, 32'h0000_0004, 32'h0);
    push_tx(1'b1, 3'd1, 32'h0000_0001, 32'h7777_7777);
    push_tx(1'b0, 3'd0, 32'h0000_0011, 32'h0);
    push_tx(1'b0, 3'd1, 32'h0000_0012, 32'h0);
    push_noxfer(2'b00, 32'h0000_0010);
    push_noxfer(2'b01, 32'h0000_0010);
    push_tx(1'b0, 3'd2, 32'h0000_0010, 32'h0);
    run_q(0);
    push_random(0, 300);
    run_q(0);

    // 256 B at 0x2000_0000 with three wait states.
    push_tx(1'b1, 3'd2, Base1 + 32'h08, 32'h0BAD_F00D);
    push_tx(1'b0, 3'd2, Base1 - 32'h04, 32'h0);
    push_noxfer(2'b00, Base1 + 32'h08);
    push_tx(1'b0, 3'd2, Base1 + 32'h08, 32'h0);
    push_tx(1'b1, 3'd2, Base1 + 32'h20, 32'h1357_9BDF);
    push_tx(1'b0, 3'd2, Base1 + 32'h20, 32'h0);
    push_tx(1'b0, 3'd2, Base1 + 32'h100, 32'h0);
    run_q(1);
    push_random(1, 150);
    run_q(1);
    reset_mid_write(1, Base1 + 32'h20);
    push_idle(70);
    push_tx(1'b0, 3'd2, Base1 + 32'h20, 32'h0);
    push_tx(1'b0, 3'd2, Base1 + 32'h08, 32'h0);
    run_q(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
